// File: rtl/fp_round_arb.sv
// fp_round_arb: two-requester arbiter that feeds one shared rounding stage.
// The result is registered together with its source index and transaction ID.
// Optional feature macro: FP_ROUND_ARB_RR_EN.
//   Defined: round-robin arbitration on contention.
//   Undefined: fixed priority, where requester 0 always wins.
// The round module is a combinational round-to-nearest-even stage.
// It takes a 26-bit mantissa: bits [25:2] are the significand and bits [1:0]
// are the guard and round bits. The loss flag is sticky; the operator bit
// says whether the lost bits made the true value larger (add) or smaller
// (subtract).

module round (
  input  logic [7:0]  exp,
  input  logic [25:0] mantis,
  input  logic        loss,
  input  logic        operator,
  output logic [7:0]  rounded_exp,
  output logic [22:0] rounded_mantis
);

  // Round-up decision.
  // A set guard bit is above half when the round bit is set or when add-sticky
  // is set. Subtract-sticky pulls the value below half. An exact tie goes to even.
  function automatic logic round_up(input logic [25:0] m, input logic l, input logic op);
    round_up = m[1] && (m[0] || (l && !op) || (!l && m[2]));
  endfunction

  logic [24:0] sum;

  // Increment the significand; a carry out renormalises into the exponent.
  always_comb begin
    sum = {1'b0, mantis[25:2]} + {24'd0, round_up(mantis, loss, operator)};
    if (sum[24]) begin
      rounded_exp    = exp + 8'd1;
      rounded_mantis = sum[23:1];
    end else begin
      rounded_exp    = exp;
      rounded_mantis = sum[22:0];
    end
  end

endmodule

module fp_round_arb #(
  parameter int ID_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [7:0]      req0_exp,
  input  logic [25:0]     req0_mantis,
  input  logic            req0_loss,
  input  logic            req0_operator,
  input  logic [ID_W-1:0] req0_id,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [7:0]      req1_exp,
  input  logic [25:0]     req1_mantis,
  input  logic            req1_loss,
  input  logic            req1_operator,
  input  logic [ID_W-1:0] req1_id,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_exp,
  output logic [22:0]     out_mantis,
  output logic            out_ovf,
  output logic            out_src,
  output logic [ID_W-1:0] out_id
);

  logic            slot_free, grant0, grant1, accept;
  logic [7:0]      exp_p0, rnd_exp_p0;
  logic [25:0]     mantis_p0;
  logic [22:0]     rnd_mantis_p0;
  logic            loss_p0, op_p0;
  logic [ID_W-1:0] id_p0;

  logic            vld_p1, ovf_p1, src_p1;
  logic [7:0]      exp_p1;
  logic [22:0]     mantis_p1;
  logic [ID_W-1:0] id_p1;

`ifdef FP_ROUND_ARB_RR_EN
  logic last_grant;
`endif

  // Arbitration: a grant is only issued when the output slot can take a result.
  always_comb begin
    slot_free = rst_n && (!vld_p1 || out_ready);
    grant0    = 1'b0;
    grant1    = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef FP_ROUND_ARB_RR_EN
      grant0 = last_grant;
      grant1 = !last_grant;
`else
      grant0 = 1'b1;
`endif
    end else if (req0_valid) begin
      grant0 = 1'b1;
    end else if (req1_valid) begin
      grant1 = 1'b1;
    end
    grant0 = grant0 && slot_free;
    grant1 = grant1 && slot_free;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 || grant1;

  // Stage p0: steer the granted request into the rounder, zeros when idle.
  always_comb begin
    exp_p0    = 8'd0;
    mantis_p0 = 26'd0;
    loss_p0   = 1'b0;
    op_p0     = 1'b0;
    id_p0     = '0;
    if (grant0) begin
      exp_p0    = req0_exp;
      mantis_p0 = req0_mantis;
      loss_p0   = req0_loss;
      op_p0     = req0_operator;
      id_p0     = req0_id;
    end else if (grant1) begin
      exp_p0    = req1_exp;
      mantis_p0 = req1_mantis;
      loss_p0   = req1_loss;
      op_p0     = req1_operator;
      id_p0     = req1_id;
    end
  end

  round u_round (
    .exp            (exp_p0),
    .mantis         (mantis_p0),
    .loss           (loss_p0),
    .operator       (op_p0),
    .rounded_exp    (rnd_exp_p0),
    .rounded_mantis (rnd_mantis_p0)
  );

`ifdef FP_ROUND_ARB_RR_EN
  // Round-robin pointer: remembers who won the last accepted transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant1;
    end
  end
`endif

  // Stage p1: result register; a drain and an accept in one cycle keep it full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      exp_p1    <= 8'd0;
      mantis_p1 <= 23'd0;
      ovf_p1    <= 1'b0;
      src_p1    <= 1'b0;
      id_p1     <= '0;
    end else if (accept) begin
      vld_p1    <= 1'b1;
      exp_p1    <= rnd_exp_p0;
      mantis_p1 <= rnd_mantis_p0;
      ovf_p1    <= (rnd_exp_p0 == 8'hFF);
      src_p1    <= grant1;
      id_p1     <= id_p0;
    end else if (out_ready) begin
      vld_p1    <= 1'b0;
    end
  end

  assign out_valid  = vld_p1;
  assign out_exp    = exp_p1;
  assign out_mantis = mantis_p1;
  assign out_ovf    = ovf_p1;
  assign out_src    = src_p1;
  assign out_id     = id_p1;

endmodule

// File: tb/tb_fp_round_arb.sv
// Testbench for fp_round_arb. It runs directed steps first, then randomized
// traffic, and checks everything against a behavioural model of the
// arbitration and rounding rules.
module tb_fp_round_arb;

  localparam int ID_W = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req0_valid, req0_ready, req0_loss, req0_operator;
  logic [7:0]      req0_exp;
  logic [25:0]     req0_mantis;
  logic [ID_W-1:0] req0_id;
  logic            req1_valid, req1_ready, req1_loss, req1_operator;
  logic [7:0]      req1_exp;
  logic [25:0]     req1_mantis;
  logic [ID_W-1:0] req1_id;
  logic            out_valid, out_ready, out_ovf, out_src;
  logic [7:0]      out_exp;
  logic [22:0]     out_mantis;
  logic [ID_W-1:0] out_id;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state
  logic            m_valid, m_ovf, m_src, m_last;
  logic [7:0]      m_exp;
  logic [22:0]     m_mant;
  logic [ID_W-1:0] m_id;
  logic            acc0, acc1;

  fp_round_arb #(.ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_exp(req0_exp),
    .req0_mantis(req0_mantis), .req0_loss(req0_loss), .req0_operator(req0_operator),
    .req0_id(req0_id),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_exp(req1_exp),
    .req1_mantis(req1_mantis), .req1_loss(req1_loss), .req1_operator(req1_operator),
    .req1_id(req1_id),
    .out_valid(out_valid), .out_ready(out_ready), .out_exp(out_exp),
    .out_mantis(out_mantis), .out_ovf(out_ovf), .out_src(out_src), .out_id(out_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference rounding done on integers.
  // The remainder is scaled by 8 so that half is 4. The sticky bit moves the
  // value up by one for add and down by one for subtract.
  function automatic logic [30:0] ref_round(input logic [7:0] e, input logic [25:0] m,
                                            input logic l, input logic op);
    longint whole, rem8;
    logic [7:0]  eo;
    logic [22:0] mo;
    whole = longint'(m) / 4;
    rem8  = (longint'(m) % 4) * 2;
    if (l) rem8 = op ? rem8 - 1 : rem8 + 1;
    if (rem8 > 4 || (rem8 == 4 && whole % 2 == 1)) whole = whole + 1;
    eo = e;
    if (whole >= 16777216) begin
      eo    = e + 8'd1;
      whole = whole / 2;
    end
    mo = 23'(whole % 8388608);
    return {eo, mo};
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_exp = '0; m_mant = '0; m_ovf = 1'b0;
    m_src = 1'b0; m_id = '0; m_last = 1'b1;
    acc0 = 1'b0; acc1 = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, 64'(out_valid), 64'(m_valid));
    check({tag, ".exp"},   64'(out_exp),   64'(m_exp));
    check({tag, ".mant"},  64'(out_mantis), 64'(m_mant));
    check({tag, ".ovf"},   64'(out_ovf),   64'(m_ovf));
    check({tag, ".src"},   64'(out_src),   64'(m_src));
    check({tag, ".id"},    64'(out_id),    64'(m_id));
  endtask

  // One clock: inputs were set at the preceding negedge.
  task automatic cycle(input string tag);
    logic free, g0, g1;
    logic [30:0] r;
    #1;
    free = !m_valid || out_ready;
    g0 = 1'b0; g1 = 1'b0;
    if (free && req0_valid && req1_valid) begin
`ifdef FP_ROUND_ARB_RR_EN
      if (m_last) g0 = 1'b1; else g1 = 1'b1;
`else
      g0 = 1'b1;
`endif
    end else if (free && req0_valid) g0 = 1'b1;
    else if (free && req1_valid) g1 = 1'b1;
    check({tag, ".ready0"}, 64'(req0_ready), 64'(g0));
    check({tag, ".ready1"}, 64'(req1_ready), 64'(g1));
    r = g1 ? ref_round(req1_exp, req1_mantis, req1_loss, req1_operator)
           : ref_round(req0_exp, req0_mantis, req0_loss, req0_operator);
    @(posedge clk);
    acc0 = g0; acc1 = g1;
    if (g0 || g1) begin
      m_valid = 1'b1;
      m_exp   = r[30:23];
      m_mant  = r[22:0];
      m_ovf   = (r[30:23] == 8'hFF);
      m_src   = g1;
      m_id    = g1 ? req1_id : req0_id;
      m_last  = g1;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic rand_req(input logic hold0, input logic hold1);
    if (!hold0) begin
      req0_valid    = ($urandom % 3) != 0;
      req0_exp      = ($urandom % 4 == 0) ? 8'hFE : 8'($urandom);
      req0_mantis   = ($urandom % 3 == 0) ? (26'h3FFFFFF ^ 26'($urandom % 8)) : 26'($urandom);
      req0_loss     = 1'($urandom);
      req0_operator = 1'($urandom);
      req0_id       = ID_W'($urandom);
    end
    if (!hold1) begin
      req1_valid    = ($urandom % 3) != 0;
      req1_exp      = ($urandom % 4 == 0) ? 8'h7F : 8'($urandom);
      req1_mantis   = ($urandom % 3 == 0) ? (26'h3FFFFFF ^ 26'($urandom % 8)) : 26'($urandom);
      req1_loss     = 1'($urandom);
      req1_operator = 1'($urandom);
      req1_id       = ID_W'($urandom);
    end
  endtask

  initial begin
    logic [7:0]  saved_exp;
    logic [22:0] saved_mant;
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_exp = 8'h11; req0_mantis = 26'h0000010; req0_loss = 1'b0;
    req0_operator = 1'b0; req0_id = 4'h1;
    req1_valid = 1'b1; req1_exp = 8'h22; req1_mantis = 26'h0000020; req1_loss = 1'b0;
    req1_operator = 1'b0; req1_id = 4'h2;
    out_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);

    // Reset state with both requests pending
    check("rst.valid", 64'(out_valid), 64'd0);
    check("rst.exp", 64'(out_exp), 64'd0);
    check("rst.mant", 64'(out_mantis), 64'd0);
    check("rst.ovf", 64'(out_ovf), 64'd0);
    check("rst.src", 64'(out_src), 64'd0);
    check("rst.id", 64'(out_id), 64'd0);
    check("rst.ready0", 64'(req0_ready), 64'd0);
    check("rst.ready1", 64'(req1_ready), 64'd0);

    // First contention after reset goes to req0, then req1 in round-robin
    rst_n = 1'b1;
    cycle("first");
    check("first.src_const", 64'(out_src), 64'd0);
    cycle("second");
`ifdef FP_ROUND_ARB_RR_EN
    check("second.src_const", 64'(out_src), 64'd1);
`else
    check("second.src_const", 64'(out_src), 64'd0);
`endif
    req0_valid = 1'b0; req1_valid = 1'b0;
    cycle("drain");

    // Single round-up on req0
    req0_valid = 1'b1; req0_exp = 8'h80; req0_mantis = 26'h0000003; req0_loss = 1'b0;
    req0_operator = 1'b0; req0_id = 4'h5;
    cycle("rup");
    req0_valid = 1'b0;
    check("rup.valid_c", 64'(out_valid), 64'd1);
    check("rup.exp_c", 64'(out_exp), 64'h80);
    check("rup.mant_c", 64'(out_mantis), 64'h1);
    check("rup.src_c", 64'(out_src), 64'd0);
    check("rup.ovf_c", 64'(out_ovf), 64'd0);

    // Carry into exponent on req1, then into overflow
    req1_valid = 1'b1; req1_exp = 8'h7F; req1_mantis = 26'h3FFFFFF; req1_loss = 1'b0;
    req1_operator = 1'b0; req1_id = 4'h6;
    cycle("carry");
    check("carry.exp_c", 64'(out_exp), 64'h80);
    check("carry.mant_c", 64'(out_mantis), 64'h0);
    check("carry.src_c", 64'(out_src), 64'd1);
    req1_exp = 8'hFE;
    cycle("ovf");
    check("ovf.exp_c", 64'(out_exp), 64'hFF);
    check("ovf.ovf_c", 64'(out_ovf), 64'd1);

    // Continuous contention at full throughput
    req0_valid = 1'b1; req0_id = 4'h3;
    req1_valid = 1'b1; req1_id = 4'h9;
    for (int i = 0; i < 6; i++) begin
      cycle("rr");
      check("rr.valid_c", 64'(out_valid), 64'd1);
`ifdef FP_ROUND_ARB_RR_EN
      check("rr.src_c", 64'(out_src), 64'(i % 2));
      check("rr.id_c", 64'(out_id), (i % 2 == 1) ? 64'h9 : 64'h3);
`else
      check("rr.src_c", 64'(out_src), 64'd0);
      check("rr.id_c", 64'(out_id), 64'h3);
`endif
    end

    // Backpressure: result held, readies low, outputs stable
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_exp = 8'h10; req1_mantis = 26'h0000004; req1_loss = 1'b0;
    req1_operator = 1'b0; req1_id = 4'hA;
    out_ready = 1'b0;
    saved_exp = m_exp; saved_mant = m_mant;
    for (int i = 0; i < 3; i++) begin
      cycle("bp");
      check("bp.exp_hold", 64'(out_exp), 64'(saved_exp));
      check("bp.mant_hold", 64'(out_mantis), 64'(saved_mant));
    end
    out_ready = 1'b1;
    #1;
    check("bp.release_ready1", 64'(req1_ready), 64'd1);
    cycle("bp_rel");
    check("bp_rel.valid_c", 64'(out_valid), 64'd1);
    check("bp_rel.src_c", 64'(out_src), 64'd1);
    check("bp_rel.exp_c", 64'(out_exp), 64'h10);
    check("bp_rel.mant_c", 64'(out_mantis), 64'h1);
    check("bp_rel.id_c", 64'(out_id), 64'hA);
    req1_valid = 1'b0;

    // Randomized traffic with random downstream stalls
    acc0 = 1'b0; acc1 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rand_req(req0_valid && !acc0, req1_valid && !acc1);
      out_ready = ($urandom % 4) != 0;
      cycle("rand");
    end

    // Asynchronous reset while a result is held
    req0_valid = 1'b1; req1_valid = 1'b0; out_ready = 1'b1;
    cycle("pre_rst");
    req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.valid", 64'(out_valid), 64'd0);
    check("async_rst.ready0", 64'(req0_ready), 64'd0);
    check("async_rst.exp", 64'(out_exp), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    cycle("post_rst");
    check("post_rst.src_c", 64'(out_src), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_round_arb.md
# fp_round_arb

Two-requester arbiter and output stage for the shared single-precision rounding datapath. The floating-point adder path (requester 0) and multiplier path (requester 1) each present a pre-rounded exponent and 26-bit mantissa. The block grants one request per cycle, passes it through one internal `round` instance, and registers the rounded result with its originating requester and ID. It sits between the normalize stages and the result writeback.

## Interface

Parameters:

- `ID_W`, default 4: width of the per-request transaction ID passed through unchanged.

Ports:

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req0_valid`, `req1_valid`  in  1 each  request present.
- `req0_ready`, `req1_ready`  out  1 each  request accepted this cycle.
- `reqN_exp`  in  8  biased exponent before rounding.
- `reqN_mantis`  in  26  mantissa with 2 guard/round bits in [1:0].
- `reqN_loss`  in  1  sticky/lost-bits flag.
- `reqN_operator`  in  1  0 = add, 1 = subtract (sticky polarity).
- `reqN_id`  in  `ID_W`  transaction ID.
- `out_valid`  out  1  result register holds a result.
- `out_ready`  in  1  downstream consumes the result.
- `out_exp`  out  8  rounded exponent.
- `out_mantis`  out  23  rounded fraction.
- `out_ovf`  out  1  rounded exponent equals 8'hFF.
- `out_src`  out  1  requester that produced the result.
- `out_id`  out  `ID_W`  ID of that request.

## Operation

- `slot_free = !out_valid || out_ready`. No grant is issued when `slot_free` is 0; both readies are 0.
- Grant:
  - Only one requester valid: that requester is granted.
  - Both valid: round-robin against `last_grant`; the requester not granted last wins.
  - `reqN_ready = slot_free && grantN`. At most one ready is high per cycle.
- `last_grant` updates only on an accepted transfer (valid && ready). It is unchanged otherwise.
- Datapath:
  - The selected request's exp, mantis, loss and operator drive the internal `round` instance combinationally.
  - With no grant, those inputs are driven to all-zero.
- On accept, the output register loads:
  - `out_exp`, `out_mantis` from the round outputs.
  - `out_ovf = (round exp_out == 8'hFF)`.
  - `out_src` = granted index and `out_id` = that request's ID.
  - `out_valid` is set to 1.
- If `out_valid && out_ready` and there is no accept in the same cycle, `out_valid` clears. The data fields hold their last value.
- Drain and accept in the same cycle: the new result replaces the old one and `out_valid` stays 1, giving full throughput.
- A requester must hold its fields stable while valid and not ready. The block does not check this.

## Timing

- Reset values: `out_valid`=0, `out_exp`=0, `out_mantis`=0, `out_ovf`=0, `out_src`=0, `out_id`=0, `last_grant`=1 (requester 0 wins the first contention).
- Readies are combinational from the valids, `out_valid`, `out_ready` and `last_grant`.
- Latency: result visible on `out_*` one cycle after the accepting edge.
- Throughput: one result per cycle while `out_ready`=1.
- Backpressure: when `out_valid`=1 and `out_ready`=0, both readies are 0 and all state holds.
- Reset asserted mid-transfer: the pending result is discarded, `out_valid` drops immediately (asynchronous), and the arbitration pointer returns to its reset value.

## Configuration

- `FP_ROUND_ARB_RR_EN` defined: round-robin arbitration as described above.
- Not defined: fixed priority. Requester 0 always wins contention. `last_grant` is not implemented and has no effect.

## Test plan

- Reset: `rst_n`=0 with both valids high -> all outputs 0, both readies 0. Release -> first contention grants req0; next cycle grants req1.
- Single round-up, req0 only: exp=8'h80, mantis=26'h0000003, loss=0 -> after 1 cycle `out_valid`=1, `out_exp`=8'h80, `out_mantis`=23'h000001, `out_src`=0, `out_ovf`=0.
- Carry into exponent, req1: exp=8'h7F, mantis=26'h3FFFFFF -> `out_exp`=8'h80, `out_mantis`=0, `out_src`=1. The same with exp=8'hFE -> `out_exp`=8'hFF, `out_ovf`=1.
- Both valid for 6 cycles, `out_ready`=1 -> accepts alternate 0,1,0,1,0,1. Each `out_id` matches its source's ID. No idle cycles.
- Backpressure: `out_ready`=0 for 3 cycles with a result held -> readies 0 and `out_*` stable. Raise `out_ready` with req1 valid -> req1 accepted in that same cycle; `out_valid` stays 1 with the new data.
- Build without `FP_ROUND_ARB_RR_EN`, both valid for 4 cycles -> req0 accepted every cycle, req1 never.
